register_window_ctrl: RTL and testbench

- SPARC-style register window controller sitting directly upstream of the register block.
- Maps 5-bit logical register numbers (r0-r31) to physical register-file addresses using the current window pointer (CWP).
- Registers the write request one cycle so data, address and enable reach the clocked register file together.
- Handles SAVE/RESTORE, the window invalid mask (WIM) and window overflow/underflow trap pulses.

---
 rtl/register_window_ctrl.sv | 140 ++++++++++++++
 tb/tb_register_window_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/register_window_ctrl.sv
// SPARC-style register window controller: maps logical r0-r31 onto the physical
// register file through CWP and handles SAVE/RESTORE, the WIM and window traps.
// Optional same-cycle read bypass outputs are enabled with `define READ_BYPASS_EN.
module register_window_ctrl #(
    parameter int NWIN = 8,
    parameter int PAW  = 8,
    parameter int CWPW = 3
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Save,
    input  logic            Restore,
    input  logic [4:0]      RA,
    input  logic [4:0]      RB,
    input  logic            WrEn,
    input  logic [4:0]      WrReg,
    input  logic [31:0]     WrData,
    input  logic            WimWE,
    input  logic [NWIN-1:0] WimIn,
    output logic [PAW-1:0]  PhysRA,
    output logic [PAW-1:0]  PhysRB,
    output logic            PhysWE,
    output logic [PAW-1:0]  PhysWA,
    output logic [31:0]     PhysWD,
    output logic [CWPW-1:0] CWP,
    output logic [NWIN-1:0] WIM,
    output logic            OvfTrap,
    output logic            UnfTrap
`ifdef READ_BYPASS_EN
    ,
    output logic            BypA,
    output logic            BypB,
    output logic [31:0]     BypD
`endif
);

    localparam int AW = PAW + 1;
    localparam logic [AW-1:0] WIN_MASK = AW'(16 * NWIN - 1);
    localparam logic [NWIN-1:0] WIM_RST = NWIN'(2'b10);

    logic [CWPW-1:0] cwp_r;
    logic [NWIN-1:0] wim_r;
    logic            phys_we_r;
    logic [PAW-1:0]  phys_wa_r;
    logic [31:0]     phys_wd_r;
    logic            ovf_r;
    logic            unf_r;
    logic [CWPW-1:0] save_tgt_s;
    logic [CWPW-1:0] rest_tgt_s;
    logic            wr_valid_s;

    // Globals r0-r7 are shared; windowed registers rotate by 16 per window so a
    // window's ins land on the next window's outs. The ring size is a power of
    // two, so the modulo reduces to a mask.
    function automatic logic [PAW-1:0] map_reg(input logic [4:0] r, input logic [CWPW-1:0] w);
        logic [AW-1:0] ofs_v;
        logic [AW-1:0] phys_v;
        if (r < 5'd8) begin
            phys_v = AW'(r);
        end else begin
            ofs_v  = (AW'(w) << 4) + AW'(r) - AW'(5'd8);
            phys_v = (ofs_v & WIN_MASK) + AW'(5'd8);
        end
        return PAW'(phys_v);
    endfunction

    // Window targets wrap naturally because NWIN is a power of two.
    assign save_tgt_s = cwp_r - CWPW'(1'b1);
    assign rest_tgt_s = cwp_r + CWPW'(1'b1);
    assign wr_valid_s = WrEn && (WrReg != 5'd0);

    // Read ports follow RA/RB through the current window in the same cycle.
    always_comb begin
        PhysRA = map_reg(RA, cwp_r);
        PhysRB = map_reg(RB, cwp_r);
    end

    // Window pointer, WIM, trap pulses and the one-cycle registered write stage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cwp_r     <= {CWPW{1'b0}};
            wim_r     <= WIM_RST;
            phys_we_r <= 1'b0;
            phys_wa_r <= {PAW{1'b0}};
            phys_wd_r <= 32'd0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else begin
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            phys_we_r <= wr_valid_s;
            if (wr_valid_s) begin
                phys_wa_r <= map_reg(WrReg, cwp_r);
                phys_wd_r <= WrData;
            end
            if (WimWE) begin
                wim_r <= WimIn;
            end
            // wim_r here is the pre-load value, so a same-cycle WIM write
            // does not affect this edge's window check.
            case ({Save, Restore})
                2'b10: begin
                    if (!wim_r[save_tgt_s]) begin
                        cwp_r <= save_tgt_s;
                    end else begin
                        ovf_r <= 1'b1;
                    end
                end
                2'b01: begin
                    if (!wim_r[rest_tgt_s]) begin
                        cwp_r <= rest_tgt_s;
                    end else begin
                        unf_r <= 1'b1;
                    end
                end
                default: begin
                    cwp_r <= cwp_r;
                end
            endcase
        end
    end

    assign PhysWE  = phys_we_r;
    assign PhysWA  = phys_wa_r;
    assign PhysWD  = phys_wd_r;
    assign CWP     = cwp_r;
    assign WIM     = wim_r;
    assign OvfTrap = ovf_r;
    assign UnfTrap = unf_r;

`ifdef READ_BYPASS_EN
    // Flags a read that targets the register being written this cycle.
    always_comb begin
        BypA = phys_we_r && (phys_wa_r == PhysRA) && (PhysRA != {PAW{1'b0}});
        BypB = phys_we_r && (phys_wa_r == PhysRB) && (PhysRB != {PAW{1'b0}});
        BypD = phys_wd_r;
    end
`endif

endmodule

// File: tb/tb_register_window_ctrl.sv
// Directed testbench for register_window_ctrl (NWIN=8, PAW=8, CWPW=3).
module tb_register_window_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Save, Restore, WrEn, WimWE;
    logic [4:0]  RA, RB, WrReg;
    logic [31:0] WrData;
    logic [7:0]  WimIn;
    logic [7:0]  PhysRA, PhysRB, PhysWA;
    logic        PhysWE, OvfTrap, UnfTrap;
    logic [31:0] PhysWD;
    logic [2:0]  CWP;
    logic [7:0]  WIM;
`ifdef READ_BYPASS_EN
    logic        BypA, BypB;
    logic [31:0] BypD;
`endif

    int n_cmp = 0;
    int n_err = 0;

    register_window_ctrl #(.NWIN(8), .PAW(8), .CWPW(3)) dut (
        .Clk(Clk), .Reset(Reset), .Save(Save), .Restore(Restore),
        .RA(RA), .RB(RB), .WrEn(WrEn), .WrReg(WrReg), .WrData(WrData),
        .WimWE(WimWE), .WimIn(WimIn),
        .PhysRA(PhysRA), .PhysRB(PhysRB), .PhysWE(PhysWE), .PhysWA(PhysWA),
        .PhysWD(PhysWD), .CWP(CWP), .WIM(WIM), .OvfTrap(OvfTrap), .UnfTrap(UnfTrap)
`ifdef READ_BYPASS_EN
        , .BypA(BypA), .BypB(BypB), .BypD(BypD)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        n_cmp++; if (PhysWE !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", PhysWE); end
        n_cmp++; if (PhysWA !== 8'd0) begin n_err++; $display("FAIL rst_wa: got %h want 00", PhysWA); end
        n_cmp++; if (PhysWD !== 32'd0) begin n_err++; $display("FAIL rst_wd: got %h want 0", PhysWD); end
        n_cmp++; if (CWP !== 3'd0) begin n_err++; $display("FAIL rst_cwp: got %0d want 0", CWP); end
        n_cmp++; if (WIM !== 8'h02) begin n_err++; $display("FAIL rst_wim: got %h want 02", WIM); end
        n_cmp++; if (OvfTrap !== 1'b0 || UnfTrap !== 1'b0) begin n_err++; $display("FAIL rst_trap: got %b%b want 00", OvfTrap, UnfTrap); end
        Reset = 1'b0;
        RA = 5'd17; RB = 5'd3;
        #1;
        n_cmp++; if (PhysRA !== 8'd17) begin n_err++; $display("FAIL map_r17: got %0d want 17", PhysRA); end
        n_cmp++; if (PhysRB !== 8'd3) begin n_err++; $display("FAIL map_g3: got %0d want 3", PhysRB); end
    endtask

    task automatic test_write;
        WrEn = 1'b1; WrReg = 5'd9; WrData = 32'h00001111;
        tick();
        WrEn = 1'b0;
        n_cmp++; if (PhysWE !== 1'b1) begin n_err++; $display("FAIL wr_we: got %b want 1", PhysWE); end
        n_cmp++; if (PhysWA !== 8'd9) begin n_err++; $display("FAIL wr_wa: got %0d want 9", PhysWA); end
        n_cmp++; if (PhysWD !== 32'h00001111) begin n_err++; $display("FAIL wr_wd: got %h want 00001111", PhysWD); end
        tick();
        n_cmp++; if (PhysWE !== 1'b0) begin n_err++; $display("FAIL wr_idle_we: got %b want 0", PhysWE); end
        n_cmp++; if (PhysWA !== 8'd9) begin n_err++; $display("FAIL wr_hold_wa: got %0d want 9", PhysWA); end
        WrEn = 1'b1; WrReg = 5'd0; WrData = 32'hDEADBEEF;
        tick();
        WrEn = 1'b0;
        n_cmp++; if (PhysWE !== 1'b0) begin n_err++; $display("FAIL wr_r0_we: got %b want 0", PhysWE); end
        n_cmp++; if (PhysWD !== 32'h00001111) begin n_err++; $display("FAIL wr_r0_wd: got %h want 00001111", PhysWD); end
    endtask

    task automatic test_save;
        Save = 1'b1;
        tick();
        Save = 1'b0;
        n_cmp++; if (CWP !== 3'd7) begin n_err++; $display("FAIL save_cwp: got %0d want 7", CWP); end
        n_cmp++; if (OvfTrap !== 1'b0) begin n_err++; $display("FAIL save_ovf: got %b want 0", OvfTrap); end
        RA = 5'd24; RB = 5'd8;
        #1;
        n_cmp++; if (PhysRA !== 8'd8) begin n_err++; $display("FAIL map_in0_w7: got %0d want 8", PhysRA); end
        n_cmp++; if (PhysRB !== 8'h78) begin n_err++; $display("FAIL map_out0_w7: got %h want 78", PhysRB); end
        RA = 5'd31;
        #1;
        n_cmp++; if (PhysRA !== 8'd15) begin n_err++; $display("FAIL map_in7_w7: got %0d want 15", PhysRA); end
        Restore = 1'b1;
        tick();
        Restore = 1'b0;
        n_cmp++; if (CWP !== 3'd0) begin n_err++; $display("FAIL restore_wrap: got %0d want 0", CWP); end
    endtask

    task automatic test_restore_trap;
        Restore = 1'b1;
        tick();
        Restore = 1'b0;
        n_cmp++; if (CWP !== 3'd0) begin n_err++; $display("FAIL unf_cwp: got %0d want 0", CWP); end
        n_cmp++; if (UnfTrap !== 1'b1) begin n_err++; $display("FAIL unf_pulse: got %b want 1", UnfTrap); end
        tick();
        n_cmp++; if (UnfTrap !== 1'b0) begin n_err++; $display("FAIL unf_width: got %b want 0", UnfTrap); end
        WimWE = 1'b1; WimIn = 8'h00;
        tick();
        WimWE = 1'b0;
        n_cmp++; if (WIM !== 8'h00) begin n_err++; $display("FAIL wim_load: got %h want 00", WIM); end
        Restore = 1'b1;
        tick();
        Restore = 1'b0;
        n_cmp++; if (CWP !== 3'd1 || UnfTrap !== 1'b0) begin n_err++; $display("FAIL restore_ok: got cwp=%0d unf=%b want 1/0", CWP, UnfTrap); end
        // WIM loaded in the same cycle as RESTORE must not block it
        WimWE = 1'b1; WimIn = 8'h04; Restore = 1'b1;
        tick();
        WimWE = 1'b0; Restore = 1'b0;
        n_cmp++; if (CWP !== 3'd2 || UnfTrap !== 1'b0 || WIM !== 8'h04) begin n_err++; $display("FAIL wim_old: got cwp=%0d unf=%b wim=%h want 2/0/04", CWP, UnfTrap, WIM); end
        WimWE = 1'b1; WimIn = 8'h02;
        tick();
        WimWE = 1'b0; Save = 1'b1;
        tick();
        Save = 1'b0;
        n_cmp++; if (CWP !== 3'd2 || OvfTrap !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got cwp=%0d ovf=%b want 2/1", CWP, OvfTrap); end
        tick();
        n_cmp++; if (OvfTrap !== 1'b0) begin n_err++; $display("FAIL ovf_width: got %b want 0", OvfTrap); end
    endtask

    task automatic test_same_edge;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        WrEn = 1'b1; WrReg = 5'd16; WrData = 32'hCAFE0016; Save = 1'b1;
        tick();
        Save = 1'b0;
        n_cmp++; if (PhysWE !== 1'b1 || PhysWA !== 8'd16) begin n_err++; $display("FAIL same_edge_wa: got we=%b wa=%0d want 1/16", PhysWE, PhysWA); end
        n_cmp++; if (CWP !== 3'd7) begin n_err++; $display("FAIL same_edge_cwp: got %0d want 7", CWP); end
        tick();
        WrEn = 1'b0;
        n_cmp++; if (PhysWA !== 8'h80) begin n_err++; $display("FAIL wr_w7_r16: got %h want 80", PhysWA); end
        Save = 1'b1; Restore = 1'b1;
        tick();
        Save = 1'b0; Restore = 1'b0;
        n_cmp++; if (CWP !== 3'd7 || OvfTrap !== 1'b0 || UnfTrap !== 1'b0) begin n_err++; $display("FAIL save_restore_nop: got cwp=%0d ovf=%b unf=%b want 7/0/0", CWP, OvfTrap, UnfTrap); end
    endtask

    task automatic test_reset_drop;
        WrEn = 1'b1; WrReg = 5'd9; WrData = 32'h12345678; Reset = 1'b1;
        tick();
        n_cmp++; if (PhysWE !== 1'b0 || PhysWA !== 8'd0) begin n_err++; $display("FAIL rst_same_edge: got we=%b wa=%h want 0/00", PhysWE, PhysWA); end
        Reset = 1'b0;
        tick();
        WrEn = 1'b0; Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_cmp++; if (PhysWE !== 1'b0 || PhysWD !== 32'd0) begin n_err++; $display("FAIL rst_drop: got we=%b wd=%h want 0/0", PhysWE, PhysWD); end
    endtask

`ifdef READ_BYPASS_EN
    task automatic test_bypass;
        WrEn = 1'b1; WrReg = 5'd9; WrData = 32'hA5A50009;
        tick();
        WrEn = 1'b0;
        RA = 5'd9; RB = 5'd10;
        #1;
        n_cmp++; if (BypA !== 1'b1) begin n_err++; $display("FAIL byp_a: got %b want 1", BypA); end
        n_cmp++; if (BypB !== 1'b0) begin n_err++; $display("FAIL byp_b: got %b want 0", BypB); end
        n_cmp++; if (BypD !== 32'hA5A50009) begin n_err++; $display("FAIL byp_d: got %h want a5a50009", BypD); end
        tick();
        n_cmp++; if (BypA !== 1'b0) begin n_err++; $display("FAIL byp_a_idle: got %b want 0", BypA); end
    endtask
`endif

    initial begin
        Reset = 1'b1; Save = 1'b0; Restore = 1'b0; WrEn = 1'b0; WimWE = 1'b0;
        RA = 5'd0; RB = 5'd0; WrReg = 5'd0; WrData = 32'd0; WimIn = 8'd0;
        test_reset();
        test_write();
        test_save();
        test_restore_trap();
        test_same_edge();
        test_reset_drop();
`ifdef READ_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
